wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter SP_RESET, default 64'h0, value loaded into x2 at reset.
REQ-002 Parameter INSTRET_EN, default 1; when 0, instret holds 0 permanently.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  freeze: no register write, no instret count, no commit update.
REQ-006 wb_valid  input  1  MEM/WB stage holds a real instruction this cycle.
REQ-007 wb_reg_write  input  1  write enable from the MEM/WB pipeline register.
REQ-008 wb_rd_addr  input  5  destination register from the MEM/WB pipeline register.
REQ-009 wb_result  input  64  write data (ALU or load result) from the MEM/WB pipeline register.
REQ-010 rs1_addr, rs2_addr  input  5 each  decode-stage read addresses.
REQ-011 rs1_data, rs2_data  output  64 each  read data, combinational, with write bypass.
REQ-012 instret  output  64  retired-instruction counter.
REQ-013 commit_valid  output  1  registered pulse: a write committed on the previous edge.
REQ-014 commit_rd  output  5  registered rd of the last committed write.
REQ-015 commit_data  output  64  registered data of the last committed write.

Function
REQ-016 Storage: 31 x 64-bit registers x1..x31; x0 has no storage and always reads 64'h0.
REQ-017 Write condition we = wb_valid & wb_reg_write & !stall & (wb_rd_addr != 0); when we is set, regs[wb_rd_addr] <= wb_result at posedge clk.
REQ-018 Write latency: a value written at edge N is readable from storage from edge N onward.
REQ-019 Bypass: if we and rsX_addr == wb_rd_addr, rsX_data = wb_result in the same cycle, before the write edge.
REQ-020 Reads of address 0 return 0 even when a write targets address 0; writes to x0 are dropped and raise no commit.
REQ-021 Both read ports are independent; identical addresses on both ports return identical data.
REQ-022 instret increments by 1 at posedge when wb_valid & !stall, regardless of wb_reg_write, so stores and branches count.
REQ-023 instret wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 without any flag.
REQ-024 commit_valid <= we each posedge; commit_rd/commit_data load wb_rd_addr/wb_result only when we, otherwise hold.
REQ-025 stall has priority over wb_valid: with stall=1, storage, instret and commit_rd/commit_data hold, and commit_valid <= 0.
REQ-026 Bypass is suppressed while stall=1, because we=0.
REQ-027 With wb_valid=0, wb_reg_write and wb_rd_addr are don't-care and no state changes except commit_valid <= 0.

Reset
REQ-028 On rst falling (assert), asynchronously: x1, x3..x31 = 0; x2 = SP_RESET; instret = 0; commit_valid = 0; commit_rd = 0; commit_data = 0.
REQ-029 Reset asserted mid-write discards that write; no partial update is permitted.
REQ-030 Read ports stay combinational during reset and return reset contents; bypass is inactive because no write occurs.
REQ-031 First write is accepted on the first posedge with rst=1.

Verification
REQ-032 Reset with SP_RESET=64'h8000: read x2 -> 64'h8000; read x5 -> 0; instret=0; commit_valid=0.
REQ-033 Write x5=64'hDEAD_BEEF (valid, reg_write) with rs1_addr=5 in the same cycle -> rs1_data=64'hDEAD_BEEF before the edge; after the edge commit_valid=1, commit_rd=5, commit_data=64'hDEAD_BEEF.
REQ-034 Write rd=0 with data 64'h1234 -> rs1_data at address 0 is 0 in the same cycle and after the edge; commit_valid=0; instret increments by 1.
REQ-035 stall=1 with a valid write to x7=64'h55 -> x7 unchanged, instret unchanged, commit_valid=0, no bypass; same input with stall=0 on the next cycle -> write and count occur.
REQ-036 Preload instret to 64'hFFFF_FFFF_FFFF_FFFE by forcing, then apply two valid non-writing instructions -> instret reads ...FFFF, then 0.
REQ-037 Assert rst asynchronously between edges while x9 holds 64'h77 and a write is pending -> x9=0 immediately and the pending write is lost after rst deasserts.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back register file: 31 x 64-bit GPRs with same-cycle write bypass,
// a retired-instruction counter and a registered commit trace port.
module wb_regfile #(
  parameter logic [63:0] SP_RESET   = 64'h0,
  parameter bit          INSTRET_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [63:0] wb_result,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  output logic [63:0] instret,
  output logic        commit_valid,
  output logic [4:0]  commit_rd,
  output logic [63:0] commit_data
);

  logic [63:0] regs_q [1:31];
  logic [63:0] regs_d [1:31];
  logic [63:0] instret_q, instret_d;
  logic        commit_valid_q, commit_valid_d;
  logic [4:0]  commit_rd_q, commit_rd_d;
  logic [63:0] commit_data_q, commit_data_d;
  logic        we;

  // Gating with rst keeps the bypass quiet while reset is held.
  assign we = rst & wb_valid & wb_reg_write & ~stall & (wb_rd_addr != 5'd0);

  function automatic logic [63:0] read_port(input logic [4:0] addr);
    logic [63:0] val;
    val = 64'h0;
    if (addr != 5'd0) begin
      if (we && (addr == wb_rd_addr)) val = wb_result;
      else                            val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wb_rd_addr] = wb_result;
  end

  always_comb begin
    instret_d = 64'h0;
    if (INSTRET_EN) begin
      instret_d = instret_q;
      if (wb_valid && !stall) instret_d = instret_q + 64'd1;
    end
  end

  always_comb begin
    commit_valid_d = we;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;
    if (we) begin
      commit_rd_d   = wb_rd_addr;
      commit_data_d = wb_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : 64'h0;
      end
      instret_q      <= 64'h0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= 5'd0;
      commit_data_q  <= 64'h0;
    end else begin
      regs_q         <= regs_d;
      instret_q      <= instret_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign instret      = instret_q;
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;

endmodule
